serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: W bits per clock, LSB digit first, D = N/W cycles per operation.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_addsub #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         Cout,
  output logic         ovf
);

  localparam int D  = N / W;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, b_q;
  logic [N-1:0]  s_q;
  logic          carry_q;
  logic          cout_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          last;
  logic [W:0]    dsum;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == LAST);
  // Current digit sits in the low W bits; operands shift right after each digit.
  assign dsum   = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      // Subtraction is x + ~y + 1, so the inversion and the +1 are folded in at capture.
      a_q     <= x;
      b_q     <= sub ? ~y : y;
      carry_q <= sub ? 1'b1 : Cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> W;
      b_q     <= b_q >> W;
      s_q     <= (s_q >> W) | (N'(dsum[W-1:0]) << (N - W));
      carry_q <= dsum[W];
      cnt_q   <= cnt_q + 1'b1;
      if (last) cout_q <= dsum[W];
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (!accept && state_q == RUN && last)
      ovf_q <= dsum[W] ^ (a_q[W-1] ^ b_q[W-1] ^ dsum[W-1]);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign Cout = cout_q;

endmodule
